universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
Parametrised successor to the team's serial-in/parallel-out shift register. Adds programmable width, left/right shift, rotate and parallel load, plus a saturating fill counter with a full flag. Used as the generic serializer/deserializer stage in the datapath. Also serves as the golden target for Saboteur fault-injection campaigns.

Parameters:
WIDTH, 8, register width in bits; must be at least 2.
CNT_W, $clog2(WIDTH+1), width of the fill counter; derived, not overridden.

Ports:
i_CLK  input  1  rising-edge clock.
i_RST_N  input  1  asynchronous active-low reset.
i_CLR  input  1  synchronous clear of register and counter.
i_EN  input  1  operation enable; when 0 the register holds.
i_MODE  input  3  operation select (encoding under Behaviour).
i_SI  input  1  serial input bit.
i_PDATA  input  WIDTH  parallel load data.
o_DATA  output  WIDTH  register contents.
o_SO_MSB  output  1  o_DATA[WIDTH-1]; bit leaving on SHL.
o_SO_LSB  output  1  o_DATA[0]; bit leaving on SHR.
o_CNT  output  CNT_W  number of valid serial bits held; saturates at WIDTH.
o_FULL  output  1  high when o_CNT == WIDTH.

Behaviour:
- Clock and reset: one clock, i_CLK. i_RST_N is asynchronous and active-low. While i_RST_N is 0: o_DATA = 0, o_CNT = 0, o_FULL = 0. Reset release takes effect at the next rising edge.
- Priority at each rising edge: i_CLR, then i_EN = 0 (hold everything), then i_MODE.
- i_CLR = 1: o_DATA <= 0, o_CNT <= 0, regardless of i_EN and i_MODE.
- i_MODE encoding (i_EN = 1):
  - 000 HOLD: no change.
  - 001 SHL: data <= {data[WIDTH-2:0], i_SI}.
  - 010 SHR: data <= {i_SI, data[WIDTH-1:1]}.
  - 011 ROL: data <= {data[WIDTH-2:0], data[WIDTH-1]}.
  - 100 ROR: data <= {data[0], data[WIDTH-1:1]}.
  - 101 LOAD: data <= i_PDATA.
  - 110, 111: treated as HOLD; no change to data or counter.
- Counter:
  - SHL/SHR increment o_CNT by 1, saturating at WIDTH (no wrap).
  - LOAD sets o_CNT to WIDTH.
  - ROL, ROR and HOLD leave o_CNT unchanged.
- o_FULL is registered-equivalent, i.e. decoded from the o_CNT register with no extra latency.
- Latency: all operations are visible on o_DATA one cycle after the sampling edge.
- Serial outputs: o_SO_MSB and o_SO_LSB are combinational taps of the current register. The bit about to be shifted out is valid before the edge that discards it.
- Reset mid-operation: the asynchronous reset overrides any mode immediately. No partial state survives.
- X safety: i_SI and i_PDATA are ignored in modes that do not use them.

Optional Feature:
Macro SR_SABOTEUR_EN.
- Defined:
  - Adds ports i_SAB_EN (1 bit) and i_SAB_MASK (WIDTH bits).
  - When i_SAB_EN = 1, o_DATA, o_SO_MSB and o_SO_LSB present register ^ i_SAB_MASK. This is a combinational bit-flip fault.
  - The internal register and counter are not corrupted.
  - i_SAB_EN = 0 gives fault-free behaviour identical to the undefined build.
- Undefined: the ports are absent and outputs come straight from the register.

Decomposition:
- Package sr_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD (3-bit);
  - a clog2-based counter-width helper function.
- One sub-module, sr_sat_counter: increment, load-to-max, clear, and saturation at a parameter MAX. It drives o_CNT and o_FULL.

Test Plan:
1. Reset and SHL fill (WIDTH=4): hold i_RST_N = 0, then release. Apply EN=1, MODE=SHL, SI = 1,0,1,1 over 4 cycles. Expect o_DATA = 1011, o_CNT = 4, o_FULL = 1; a 5th SHL keeps o_CNT = 4.
2. Shift right and serial out: LOAD 1001. Then SHR with SI = 0 four times. Expect o_SO_LSB sequence 1,0,0,1 before each edge and final o_DATA = 0000.
3. Rotate: LOAD 1000. ROL ×4 gives 0001, 0010, 0100, 1000. ROR ×1 gives 0100. o_CNT stays 4 throughout.
4. Enable and clear priority: with i_EN = 0 and MODE=LOAD 1111, o_DATA is unchanged. With i_CLR = 1 and EN=1, MODE=LOAD 1111, expect o_DATA = 0000 and o_CNT = 0.
5. Async reset mid-shift: assert i_RST_N = 0 between clock edges during SHL. o_DATA = 0 and o_CNT = 0 immediately, without waiting for an edge.
6. Saboteur build only (SR_SABOTEUR_EN defined): LOAD 1010. With SAB_EN = 1 and MASK = 0011, expect o_DATA = 1001. After SAB_EN = 0, expect 1010, confirming the internal state was not corrupted.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared mode encodings and width helpers for the universal shift register.
// Optional fault-injection ports are enabled with SR_SABOTEUR_EN (see top).
package sr_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_sat_counter.sv
// Saturating fill counter: clear, load-to-max, increment stopping at MAX.
module sr_sat_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         load_max,
    output logic [W-1:0] cnt,
    output logic         full
);

    localparam logic [W-1:0] MAX_VAL = W'(MAX);

    logic [W-1:0] cnt_q;

    // Clear dominates load, load dominates increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load_max) begin
            cnt_q <= MAX_VAL;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == MAX_VAL);

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate/load with a saturating fill counter.
// Define SR_SABOTEUR_EN to add combinational output bit-flip injection ports.
module universal_shift_register
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_CLR,
    input  logic              i_EN,
    input  logic [MODE_W-1:0] i_MODE,
    input  logic              i_SI,
    input  logic [WIDTH-1:0]  i_PDATA,
`ifdef SR_SABOTEUR_EN
    input  logic              i_SAB_EN,
    input  logic [WIDTH-1:0]  i_SAB_MASK,
`endif
    output logic [WIDTH-1:0]  o_DATA,
    output logic              o_SO_MSB,
    output logic              o_SO_LSB,
    output logic [CNT_W-1:0]  o_CNT,
    output logic              o_FULL
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_view;
    logic             is_shift;
    logic             is_load;

    // Data register; modes 110/111 fall into the hold default.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            data_q <= '0;
        end else if (i_CLR) begin
            data_q <= '0;
        end else if (i_EN) begin
            case (i_MODE)
                MODE_SHL:  data_q <= {data_q[WIDTH-2:0], i_SI};
                MODE_SHR:  data_q <= {i_SI, data_q[WIDTH-1:1]};
                MODE_ROL:  data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                MODE_ROR:  data_q <= {data_q[0], data_q[WIDTH-1:1]};
                MODE_LOAD: data_q <= i_PDATA;
                default:   data_q <= data_q;
            endcase
        end
    end

    assign is_shift = i_EN && ((i_MODE == MODE_SHL) || (i_MODE == MODE_SHR));
    assign is_load  = i_EN && (i_MODE == MODE_LOAD);

    sr_sat_counter #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_cnt (
        .clk      (i_CLK),
        .rst_n    (i_RST_N),
        .clr      (i_CLR),
        .inc      (is_shift),
        .load_max (is_load),
        .cnt      (o_CNT),
        .full     (o_FULL)
    );

    // Fault injection corrupts only the visible view, never the stored state.
`ifdef SR_SABOTEUR_EN
    assign data_view = data_q ^ (i_SAB_EN ? i_SAB_MASK : '0);
`else
    assign data_view = data_q;
`endif

    assign o_DATA   = data_view;
    assign o_SO_MSB = data_view[WIDTH-1];
    assign o_SO_LSB = data_view[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register at WIDTH=4.
// Saboteur checks run only when SR_SABOTEUR_EN is defined.
module tb_universal_shift_register;
    import sr_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             en;
    logic [2:0]       mode;
    logic             si;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] data;
    logic             so_msb;
    logic             so_lsb;
    logic [CNT_W-1:0] cnt;
    logic             full;
`ifdef SR_SABOTEUR_EN
    logic             sab_en;
    logic [WIDTH-1:0] sab_mask;
`endif

    int n_checks = 0;
    int n_errors = 0;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_CLR      (clr),
        .i_EN       (en),
        .i_MODE     (mode),
        .i_SI       (si),
        .i_PDATA    (pdata),
`ifdef SR_SABOTEUR_EN
        .i_SAB_EN   (sab_en),
        .i_SAB_MASK (sab_mask),
`endif
        .o_DATA     (data),
        .o_SO_MSB   (so_msb),
        .o_SO_LSB   (so_lsb),
        .o_CNT      (cnt),
        .o_FULL     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Set inputs, wait for the next rising edge, then settle 1 time unit.
    task automatic step(input logic [2:0] m, input logic s, input logic [WIDTH-1:0] p);
        mode  = m;
        si    = s;
        pdata = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] d,
                               input logic [CNT_W-1:0] c, input logic f);
        check({tag, "_data"}, 32'(data), 32'(d));
        check({tag, "_cnt"},  32'(cnt),  32'(c));
        check({tag, "_full"}, 32'(full), 32'(f));
    endtask

    initial begin
        logic [WIDTH-1:0] exp_d;
        logic [3:0]       si_seq;
        logic [3:0]       lsb_seq;
        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        mode  = MODE_HOLD;
        si    = 1'b0;
        pdata = '0;
`ifdef SR_SABOTEUR_EN
        sab_en   = 1'b0;
        sab_mask = '0;
`endif
        #12;
        check_state("reset", 4'b0000, 3'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        // SHL fill with SI = 1,0,1,1
        si_seq = 4'b1011;
        exp_d  = '0;
        for (int i = 3; i >= 0; i--) begin
            step(MODE_SHL, si_seq[i], 4'b1111);
            exp_d = {exp_d[2:0], si_seq[i]};
            check_state($sformatf("shl%0d", 3 - i), exp_d, 3'(4 - i), i == 0);
        end
        check("shl_msb", 32'(so_msb), 32'd1);
        check("shl_lsb", 32'(so_lsb), 32'd1);
        step(MODE_SHL, 1'b0, 4'b0000);
        check_state("shl_sat", 4'b0110, 3'd4, 1'b1);

        // SHR drain with serial-out observed before each edge
        step(MODE_LOAD, 1'b1, 4'b1001);
        check_state("load1001", 4'b1001, 3'd4, 1'b1);
        lsb_seq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            mode = MODE_SHR;
            si   = 1'b0;
            #1;
            check($sformatf("shr_so_lsb%0d", i), 32'(so_lsb), 32'(lsb_seq[3 - i]));
            step(MODE_SHR, 1'b0, 4'b1111);
        end
        check_state("shr_end", 4'b0000, 3'd4, 1'b1);

        // Rotate
        step(MODE_LOAD, 1'b0, 4'b1000);
        step(MODE_ROL, 1'b1, 4'b1111);
        check_state("rol1", 4'b0001, 3'd4, 1'b1);
        step(MODE_ROL, 1'b1, 4'b1111);
        check_state("rol2", 4'b0010, 3'd4, 1'b1);
        step(MODE_ROL, 1'b1, 4'b1111);
        check_state("rol3", 4'b0100, 3'd4, 1'b1);
        step(MODE_ROL, 1'b1, 4'b1111);
        check_state("rol4", 4'b1000, 3'd4, 1'b1);
        step(MODE_ROR, 1'b1, 4'b1111);
        check_state("ror1", 4'b0100, 3'd4, 1'b1);

        // Enable and clear priority
        en = 1'b0;
        step(MODE_LOAD, 1'b1, 4'b1111);
        check_state("en_hold", 4'b0100, 3'd4, 1'b1);
        en  = 1'b1;
        clr = 1'b1;
        step(MODE_LOAD, 1'b1, 4'b1111);
        check_state("clr", 4'b0000, 3'd0, 1'b0);
        clr = 1'b0;

        // Counter increments from clear; reserved modes hold
        step(MODE_SHL, 1'b1, 4'b0000);
        check_state("shl_from_clr", 4'b0001, 3'd1, 1'b0);
        step(MODE_SHR, 1'b1, 4'b0000);
        check_state("shr_from_clr", 4'b1000, 3'd2, 1'b0);
        step(3'b110, 1'b1, 4'b1111);
        check_state("mode110", 4'b1000, 3'd2, 1'b0);
        step(3'b111, 1'b1, 4'b1111);
        check_state("mode111", 4'b1000, 3'd2, 1'b0);
        step(MODE_HOLD, 1'b1, 4'b1111);
        check_state("hold", 4'b1000, 3'd2, 1'b0);

        // Async reset between edges during SHL
        step(MODE_SHL, 1'b1, 4'b0000);
        check_state("pre_rst", 4'b0001, 3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(MODE_SHL, 1'b1, 4'b0000);
        check_state("post_rst", 4'b0001, 3'd1, 1'b0);

`ifdef SR_SABOTEUR_EN
        step(MODE_LOAD, 1'b0, 4'b1010);
        sab_en   = 1'b1;
        sab_mask = 4'b0011;
        #1;
        check("sab_data", 32'(data), 32'(4'b1001));
        check("sab_lsb",  32'(so_lsb), 32'd1);
        check("sab_cnt",  32'(cnt), 32'd4);
        sab_en = 1'b0;
        #1;
        check("sab_off_data", 32'(data), 32'(4'b1010));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
